// File: rtl/dpram_be_arb.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle read latency,
// cross-port RDW control, write-collision arbitration and post-reset clear.
// Optional per-byte even parity: define DPRAM_BE_ARB_PARITY_EN.
module dpram_be_arb #(
  parameter int    DWIDTH         = 32,
  parameter int    AWIDTH         = 10,
  parameter int    RD_LAT         = 1,
  parameter string RDW_MODE       = "OLD",
  parameter string PRIORITY       = "A",
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DWIDTH/8-1:0] a_be,
  input  logic [AWIDTH-1:0]   a_addr,
  input  logic [DWIDTH-1:0]   a_wdata,
  output logic [DWIDTH-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [DWIDTH/8-1:0] b_be,
  input  logic [AWIDTH-1:0]   b_addr,
  input  logic [DWIDTH-1:0]   b_wdata,
  output logic [DWIDTH-1:0]   b_rdata,
  output logic                b_rvalid,
`ifdef DPRAM_BE_ARB_PARITY_EN
  output logic [DWIDTH/8-1:0] a_perr,
  output logic [DWIDTH/8-1:0] b_perr,
`endif
  output logic                collision
);

  localparam int NB    = DWIDTH / 8;
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int HI    = (PRIORITY == "B") ? 1 : 0;
  localparam int LO    = 1 - HI;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] clr_cnt;
  logic              clr_we;

  // Port A is index 0, port B is index 1.
  logic [1:0]        req, we, wr, rd;
  logic [NB-1:0]     be    [2];
  logic [AWIDTH-1:0] addr  [2];
  logic [DWIDTH-1:0] wdata [2];
  logic [DWIDTH-1:0] rd_word [2];

  assign req      = {b_req, a_req};
  assign we       = {b_we, a_we};
  assign be[0]    = a_be;
  assign be[1]    = b_be;
  assign addr[0]  = a_addr;
  assign addr[1]  = b_addr;
  assign wdata[0] = a_wdata;
  assign wdata[1] = b_wdata;
  assign wr       = req & we & {2{~busy}};
  assign rd       = req & ~we & {2{~busy}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_cnt <= clr_cnt + AWIDTH'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_CLEAR: begin
        clr_we = ~rst;
        if (!rst && (&clr_cnt)) state_nxt = ST_READY;
      end
      ST_READY: busy = rst;
      default:  state_nxt = ST_READY;
    endcase
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; only the clear sequencer zeroes it.
  // Both ports' lanes are assigned in one process; the priority port's
  // non-blocking assignment comes last and therefore wins a shared lane.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_cnt] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (wr[LO] && be[LO][i]) mem[addr[LO]][8*i +: 8] <= wdata[LO][8*i +: 8];
      if (wr[HI] && be[HI][i]) mem[addr[HI]][8*i +: 8] <= wdata[HI][8*i +: 8];
    end
  end

  // In NEW mode a read sees the other port's same-cycle write lanes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[addr[p]];
      if (RDW_MODE == "NEW" && wr[1-p] && (addr[1-p] == addr[p])) begin
        for (int i = 0; i < NB; i++)
          if (be[1-p][i]) rd_word[p][8*i +: 8] = wdata[1-p][8*i +: 8];
      end
    end
  end

  logic [1:0]        s1_v, rv_q;
  logic [DWIDTH-1:0] s1_d [2];
  logic [DWIDTH-1:0] rd_q [2];

  // Output data registers only load on a valid beat, so rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= '0;
      rv_q <= '0;
      for (int p = 0; p < 2; p++) begin
        s1_d[p] <= '0;
        rd_q[p] <= '0;
      end
    end else begin
      s1_v <= rd;
      rv_q <= (RD_LAT == 1) ? rd : s1_v;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) s1_d[p] <= rd_word[p];
        if (RD_LAT == 1) begin
          if (rd[p]) rd_q[p] <= rd_word[p];
        end else begin
          if (s1_v[p]) rd_q[p] <= s1_d[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= (&wr) && (addr[0] == addr[1]) && (|(be[0] & be[1]));
  end

  assign a_rdata  = rd_q[0];
  assign b_rdata  = rd_q[1];
  assign a_rvalid = rv_q[0];
  assign b_rvalid = rv_q[1];

`ifdef DPRAM_BE_ARB_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par  [2];
  logic [NB-1:0] rd_perr [2];
  logic [NB-1:0] s1_e    [2];
  logic [NB-1:0] perr_q  [2];

  // Stored bit is the XOR of the byte, so byte plus parity has even weight.
  always_ff @(posedge clk) begin
    if (clr_we) par_mem[clr_cnt] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (wr[LO] && be[LO][i]) par_mem[addr[LO]][i] <= ^wdata[LO][8*i +: 8];
      if (wr[HI] && be[HI][i]) par_mem[addr[HI]][i] <= ^wdata[HI][8*i +: 8];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_par[p] = par_mem[addr[p]];
      if (RDW_MODE == "NEW" && wr[1-p] && (addr[1-p] == addr[p])) begin
        for (int i = 0; i < NB; i++)
          if (be[1-p][i]) rd_par[p][i] = ^wdata[1-p][8*i +: 8];
      end
      for (int i = 0; i < NB; i++)
        rd_perr[p][i] = (^rd_word[p][8*i +: 8]) ^ rd_par[p][i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        s1_e[p]   <= '0;
        perr_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_e[p]   <= rd[p] ? rd_perr[p] : '0;
        perr_q[p] <= (RD_LAT == 1) ? (rd[p] ? rd_perr[p] : '0) : s1_e[p];
      end
    end
  end

  assign a_perr = perr_q[0];
  assign b_perr = perr_q[1];
`endif

endmodule

// File: tb/tb_dpram_be_arb.sv
// Scoreboard bench for dpram_be_arb: two instances (RD_LAT=1/OLD/PRIORITY A and
// RD_LAT=2/NEW/PRIORITY B) share stimulus; a negedge monitor checks all outputs.
module tb_dpram_be_arb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NB = 4;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic [NB-1:0] perr;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req, a_we, b_req, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          busy1, a_rvalid1, b_rvalid1, coll1;
  logic          busy2, a_rvalid2, b_rvalid2, coll2;
  logic [DW-1:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;
`ifdef DPRAM_BE_ARB_PARITY_EN
  logic [NB-1:0] a_perr1, b_perr1, a_perr2, b_perr2;
`endif

  dpram_be_arb #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(1), .RDW_MODE("OLD"),
                 .PRIORITY("A"), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
`ifdef DPRAM_BE_ARB_PARITY_EN
    .a_perr(a_perr1), .b_perr(b_perr1),
`endif
    .collision(coll1)
  );

  dpram_be_arb #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(2), .RDW_MODE("NEW"),
                 .PRIORITY("B"), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_dut2 (
    .clk(clk), .rst(rst), .busy(busy2),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
`ifdef DPRAM_BE_ARB_PARITY_EN
    .a_perr(a_perr2), .b_perr(b_perr2),
`endif
    .collision(coll2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   accepting = 1'b0;

  function automatic string ch_name(input int c);
    case (c)
      0: return "dut1_a_read";
      1: return "dut1_b_read";
      2: return "dut2_a_read";
      3: return "dut2_b_read";
      4: return "dut1_collision";
      default: return "dut2_collision";
    endcase
  endfunction

  function automatic void get_ch(input int c, output logic v,
                                 output logic [DW-1:0] d, output logic [NB-1:0] pe);
    d  = '0;
    pe = '0;
    case (c)
      0: begin v = a_rvalid1; d = a_rdata1; end
      1: begin v = b_rvalid1; d = b_rdata1; end
      2: begin v = a_rvalid2; d = a_rdata2; end
      3: begin v = b_rvalid2; d = b_rdata2; end
      4: v = coll1;
      default: v = coll2;
    endcase
`ifdef DPRAM_BE_ARB_PARITY_EN
    case (c)
      0: pe = a_perr1;
      1: pe = b_perr1;
      2: pe = a_perr2;
      3: pe = b_perr2;
      default: pe = '0;
    endcase
`endif
  endfunction

  // Monitor: pops the oldest expectation of a channel whenever it presents output.
  always @(negedge clk) begin
    int            idx;
    logic          v;
    logic [DW-1:0] d;
    logic [NB-1:0] pe;
    for (int c = 0; c < 6; c++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].ch == c) begin idx = i; break; end
      get_ch(c, v, d, pe);
      if (v) begin
        n_vec++;
        if (idx < 0) begin
          n_err++;
          $display("FAIL %s: unexpected output data=%h at cyc %0d, none required",
                   ch_name(c), d, cyc);
        end else begin
          if (d !== sb[idx].data || pe !== sb[idx].perr || sb[idx].due != cyc) begin
            n_err++;
            $display("FAIL %s: got data=%h perr=%b at cyc %0d, want data=%h perr=%b at cyc %0d",
                     ch_name(c), d, pe, cyc, sb[idx].data, sb[idx].perr, sb[idx].due);
          end
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: no output by cyc %0d, want data=%h at cyc %0d",
                 ch_name(c), cyc, sb[idx].data, sb[idx].due);
        sb.delete(idx);
      end
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic op_t rd_op(input logic [AW-1:0] ad);
    op_t o;
    o      = '0;
    o.req  = 1'b1;
    o.addr = ad;
    return o;
  endfunction

  function automatic op_t wr_op(input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                                input logic [NB-1:0] b);
    op_t o;
    o       = '0;
    o.req   = 1'b1;
    o.we    = 1'b1;
    o.be    = b;
    o.addr  = ad;
    o.wdata = wd;
    return o;
  endfunction

  task automatic drive(input op_t a, input op_t b);
    a_req = a.req; a_we = a.we; a_be = a.be; a_addr = a.addr; a_wdata = a.wdata;
    b_req = b.req; b_we = b.we; b_be = b.be; b_addr = b.addr; b_wdata = b.wdata;
  endtask

  task automatic expect_out(input int ch, input logic [DW-1:0] d,
                            input logic [NB-1:0] pe, input int lat);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    e.perr = pe;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; ea*/eb* are the hand-computed read results per instance.
  task automatic step(input op_t a, input op_t b,
                      input logic [DW-1:0] ea1, ea2, eb1, eb2,
                      input logic coll, input logic [NB-1:0] pea);
    drive(a, b);
    if (accepting) begin
      if (a.req && !a.we) begin expect_out(0, ea1, pea, 1); expect_out(2, ea2, pea, 2); end
      if (b.req && !b.we) begin expect_out(1, eb1, '0, 1);  expect_out(3, eb2, '0, 2);  end
      if (coll) begin expect_out(4, '0, '0, 1); expect_out(5, '0, '0, 1); end
    end
    @(posedge clk);
    #1;
    drive('0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic reset_checks();
    check("busy1_in_reset", {31'd0, busy1}, 32'd1);
    check("busy2_in_reset", {31'd0, busy2}, 32'd1);
    check("a_rdata1_in_reset", a_rdata1, 32'h0);
    check("b_rdata1_in_reset", b_rdata1, 32'h0);
    check("a_rdata2_in_reset", a_rdata2, 32'h0);
    check("b_rdata2_in_reset", b_rdata2, 32'h0);
    check("collision_in_reset", {30'd0, coll1, coll2}, 32'd0);
  endtask

  // Counts busy cycles after rst release; optionally hammers the ports meanwhile.
  task automatic count_clear(input bit poke);
    int n1 = 0;
    int n2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (poke) drive(wr_op(4'd0, 32'hDEADBEEF, 4'hF), rd_op(4'd0));
      @(negedge clk);
      if (busy1) n1++;
      if (busy2) n2++;
      if (!busy1 && !busy2) break;
      @(posedge clk);
      #1;
    end
    drive('0, '0);
    check("clear_busy_cycles_dut1", n1, 32'd16);
    check("clear_busy_cycles_dut2", n2, 32'd16);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    drive('0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_clear(1'b0);
    accepting = 1'b1;

    // Every word reads back zero; both ports stream 8 back-to-back reads.
    for (int i = 0; i < 8; i++)
      step(rd_op(AW'(i)), rd_op(AW'(i + 8)), '0, '0, '0, '0, 1'b0, '0);

    for (int i = 0; i < 8; i++)
      step(wr_op(AW'(i), 32'hA0A00000 | i, 4'hF), wr_op(AW'(i + 8), 32'hB0B00000 | i, 4'hF),
           '0, '0, '0, '0, 1'b0, '0);

    for (int i = 0; i < 8; i++)
      step(rd_op(AW'(i + 8)), rd_op(AW'(i)), 32'hB0B00000 | i, 32'hB0B00000 | i,
           32'hA0A00000 | i, 32'hA0A00000 | i, 1'b0, '0);

    // Byte-enable merge and be=0 no-op at addr 3.
    step(wr_op(4'd3, 32'h11223344, 4'hF), '0, '0, '0, '0, '0, 1'b0, '0);
    step(wr_op(4'd3, 32'hAABBCCDD, 4'h5), '0, '0, '0, '0, '0, 1'b0, '0);
    step('0, rd_op(4'd3), '0, '0, 32'h11BB33DD, 32'h11BB33DD, 1'b0, '0);
    step(wr_op(4'd3, 32'hFFFFFFFF, 4'h0), '0, '0, '0, '0, '0, 1'b0, '0);
    step(rd_op(4'd3), '0, 32'h11BB33DD, 32'h11BB33DD, '0, '0, 1'b0, '0);

    // Cross-port read-during-write at addr 7 (dut1 OLD, dut2 NEW).
    step(wr_op(4'd7, 32'hFFFFFFFF, 4'hF), rd_op(4'd7), '0, '0,
         32'hA0A00007, 32'hFFFFFFFF, 1'b0, '0);
    step(wr_op(4'd7, 32'h12345678, 4'h3), rd_op(4'd7), '0, '0,
         32'hFFFFFFFF, 32'hFFFF5678, 1'b0, '0);
    step(rd_op(4'd7), wr_op(4'd7, 32'h00000000, 4'hC), 32'hFFFF5678, 32'h00005678,
         '0, '0, 1'b0, '0);
    step(rd_op(4'd7), rd_op(4'd7), 32'h00005678, 32'h00005678,
         32'h00005678, 32'h00005678, 1'b0, '0);

    // Double write at addr 9: dut1 gives port A the shared lane, dut2 port B.
    step(wr_op(4'd9, 32'h0, 4'hF), '0, '0, '0, '0, '0, 1'b0, '0);
    step(wr_op(4'd9, 32'h01010101, 4'h3), wr_op(4'd9, 32'h02020202, 4'h6),
         '0, '0, '0, '0, 1'b1, '0);
    step(rd_op(4'd9), '0, 32'h00020101, 32'h00020201, '0, '0, 1'b0, '0);
    step(wr_op(4'd9, 32'h01010101, 4'h3), wr_op(4'd10, 32'h02020202, 4'h6),
         '0, '0, '0, '0, 1'b0, '0);
    step(wr_op(4'd9, 32'h0000AAAA, 4'h3), wr_op(4'd9, 32'hBBBB0000, 4'hC),
         '0, '0, '0, '0, 1'b0, '0);
    step(rd_op(4'd9), rd_op(4'd10), 32'hBBBBAAAA, 32'hBBBBAAAA,
         32'hB0020202, 32'hB0020202, 1'b0, '0);

`ifdef DPRAM_BE_ARB_PARITY_EN
    // Corrupt lane 2 parity of addr 5; only that lane of that read reports.
    u_dut1.par_mem[5][2] = ~u_dut1.par_mem[5][2];
    u_dut2.par_mem[5][2] = ~u_dut2.par_mem[5][2];
    step(rd_op(4'd5), rd_op(4'd6), 32'hA0A00005, 32'hA0A00005,
         32'hA0A00006, 32'hA0A00006, 1'b0, 4'b0100);
    step(rd_op(4'd4), rd_op(4'd4), 32'hA0A00004, 32'hA0A00004,
         32'hA0A00004, 32'hA0A00004, 1'b0, 4'b0000);
`endif

    idle(4);

    // Reset mid-clear restarts the sweep; requests during busy are dropped.
    accepting = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_clear(1'b1);
    accepting = 1'b1;

    for (int i = 0; i < 8; i++)
      step(rd_op(AW'(i)), rd_op(AW'(i + 8)), '0, '0, '0, '0, 1'b0, '0);
    idle(4);

    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: expectation never met, want data=%h at cyc %0d",
               ch_name(sb[0].ch), sb[0].data, sb[0].due);
      sb.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
